// File: rtl/bsg_link_sdr_credit_tx_pkg.sv
// Chip-level defaults for the SDR link credit transmitter.
// The transmitter and its credit counter import this package and use these
// values as their parameter defaults.
//   width_gp                          link data width
//   lg_fifo_depth_gp                  log2 of far-end receive FIFO depth
//   lg_credit_to_token_decimation_gp  log2 of credits returned per token edge
package bsg_link_sdr_credit_tx_pkg;

    localparam int unsigned width_gp                         = 32;
    localparam int unsigned lg_fifo_depth_gp                 = 3;
    localparam int unsigned lg_credit_to_token_decimation_gp = 0;

endpackage

// File: rtl/bsg_link_sdr_credit_tx_if.sv
// Valid/ready source handshake into the SDR link credit transmitter.
//   data       word to send
//   v          data valid
//   ready_and  transmitter can accept this cycle (independent of v)
// master: the core-side source; slave: the transmitter.
interface bsg_link_sdr_credit_tx_if #(
    parameter int unsigned width_p = 32
) ();

    logic [width_p-1:0] data;
    logic               v;
    logic               ready_and;

    modport master (output data, output v, input ready_and);
    modport slave  (input data, input v, output ready_and);

endinterface

// File: rtl/bsg_link_sdr_credit_counter.sv
// Credit bookkeeping for one SDR link lane: token edge detect, saturating
// up/down credit counter, and optional sticky overflow flag.
// Optional feature macro: BSG_LINK_SDR_CREDIT_CHECK_EN (overflow flag,
// simulation error report and credit range assertion).
// Ports:
//   clk_i           clock, rising edge
//   reset_i         synchronous active-high reset
//   token_i         synchronized token level; each rising edge returns credits
//   dec_i           a word is sent this cycle (consumes one credit)
//   credit_count_o  current credits
//   error_o         sticky overflow flag (tied 0 when checking is disabled)
module bsg_link_sdr_credit_counter
    import bsg_link_sdr_credit_tx_pkg::*;
#(
    parameter int unsigned lg_fifo_depth_p                 = lg_fifo_depth_gp,
    parameter int unsigned lg_credit_to_token_decimation_p = lg_credit_to_token_decimation_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     token_i,
    input  logic                     dec_i,
    output logic [lg_fifo_depth_p:0] credit_count_o,
    output logic                     error_o
);

    localparam int unsigned cnt_w         = lg_fifo_depth_p + 1;
    localparam int unsigned sum_w         = lg_fifo_depth_p + 2;
    localparam int unsigned max_credits   = 1 << lg_fifo_depth_p;
    localparam int unsigned token_credits = 1 << lg_credit_to_token_decimation_p;

    if (lg_credit_to_token_decimation_p > lg_fifo_depth_p) begin : g_bad_decimation
        $error("token decimation %0d exceeds fifo depth log2 %0d",
               lg_credit_to_token_decimation_p, lg_fifo_depth_p);
    end

    logic             token_r;
    logic             token_edge;
    logic [cnt_w-1:0] credits_r;
    logic [sum_w-1:0] sum;
    logic             overflow;

    // One token per rising level change; token_r is cleared by reset so a
    // token held high across reset release still counts once.
    assign token_edge = token_i & ~token_r;

    // Next credit value with one extra bit of headroom to see overflow.
    // dec_i only happens with nonzero credits, so no underflow is possible.
    always_comb begin
        sum = sum_w'(credits_r);
        if (token_edge) begin
            sum = sum + sum_w'(token_credits);
        end
        if (dec_i) begin
            sum = sum - sum_w'(1);
        end
    end

    assign overflow = (sum > sum_w'(max_credits));

    // Credit register and token history.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            token_r   <= 1'b0;
            credits_r <= cnt_w'(max_credits);
        end else begin
            token_r   <= token_i;
            credits_r <= overflow ? cnt_w'(max_credits) : sum[cnt_w-1:0];
        end
    end

    assign credit_count_o = credits_r;

`ifdef BSG_LINK_SDR_CREDIT_CHECK_EN
    logic error_r;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_r <= 1'b0;
        end else if (overflow) begin
            error_r <= 1'b1;
        end
    end

    assign error_o = error_r;

    // Simulation-only reporting of credit overflow and range.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (overflow) begin
                $error("credit overflow: credits would reach %0d, max %0d",
                       sum, max_credits);
            end
            assert (credits_r <= cnt_w'(max_credits))
                else $error("credit count %0d above max %0d", credits_r, max_credits);
        end
    end
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: rtl/bsg_link_sdr_credit_tx.sv
// Core-clock transmitter for one SDR link lane. Accepts words from a
// valid/ready source, drives registered link data/valid, and meters traffic
// with a credit counter replenished by token edges from the receiver.
// Optional feature macro: BSG_LINK_SDR_CREDIT_CHECK_EN (see credit counter).
// Ports:
//   clk_i           clock, rising edge
//   reset_i         synchronous active-high reset
//   src             slave side of the source handshake (data, v, ready_and)
//   token_i         synchronized token level from the receiver
//   link_data_o     registered link data (holds when idle)
//   link_v_o        registered link valid
//   credit_count_o  current credits
//   error_o         sticky credit overflow flag
module bsg_link_sdr_credit_tx
    import bsg_link_sdr_credit_tx_pkg::*;
#(
    parameter int unsigned width_p                         = width_gp,
    parameter int unsigned lg_fifo_depth_p                 = lg_fifo_depth_gp,
    parameter int unsigned lg_credit_to_token_decimation_p = lg_credit_to_token_decimation_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bsg_link_sdr_credit_tx_if.slave        src,
    input  logic                           token_i,
    output logic [width_p-1:0]             link_data_o,
    output logic                           link_v_o,
    output logic [lg_fifo_depth_p:0]       credit_count_o,
    output logic                           error_o
);

    logic ready_and;
    logic xfer;

    // Ready uses pre-update credits only; it never looks at v.
    assign ready_and     = (credit_count_o != '0) & ~reset_i;
    assign src.ready_and = ready_and;
    assign xfer          = src.v & ready_and;

    // Link output registers; data holds its last value while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            link_v_o    <= 1'b0;
            link_data_o <= '0;
        end else begin
            link_v_o <= xfer;
            if (xfer) begin
                link_data_o <= src.data;
            end
        end
    end

    bsg_link_sdr_credit_counter #(
        .lg_fifo_depth_p                 (lg_fifo_depth_p),
        .lg_credit_to_token_decimation_p (lg_credit_to_token_decimation_p)
    ) u_credit (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .token_i        (token_i),
        .dec_i          (xfer),
        .credit_count_o (credit_count_o),
        .error_o        (error_o)
    );

endmodule

// File: tb/tb_bsg_link_sdr_credit_tx.sv
// Self-checking bench for bsg_link_sdr_credit_tx (width 32, depth 8, T=2).
module tb_bsg_link_sdr_credit_tx;

    localparam int unsigned W   = 32;
    localparam int unsigned LG  = 3;
    localparam int unsigned LGT = 1;
    localparam int          MAX = 8;
    localparam int          T   = 2;
`ifdef BSG_LINK_SDR_CREDIT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          token;
    logic [W-1:0]  link_data;
    logic          link_v;
    logic [LG:0]   credit_count;
    logic          error;

    bsg_link_sdr_credit_tx_if #(.width_p(W)) src ();

    bsg_link_sdr_credit_tx #(
        .width_p                         (W),
        .lg_fifo_depth_p                 (LG),
        .lg_credit_to_token_decimation_p (LGT)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .src            (src),
        .token_i        (token),
        .link_data_o    (link_data),
        .link_v_o       (link_v),
        .credit_count_o (credit_count),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [W-1:0] expq[$];

    // Reference model state (what the DUT should show this cycle).
    bit           m_valid = 1'b0;
    int           m_credits;
    bit           m_tok;
    bit           m_err;
    bit           m_link_v;
    logic [W-1:0] m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: compare current outputs, then advance from inputs about to be sampled.
    always @(negedge clk) begin
        bit xfer;
        bit tok_edge;
        int sum;
        if (m_valid) begin
            chk("credit_count", 64'(credit_count), 64'(m_credits));
            chk("ready_and", 64'(src.ready_and), 64'((m_credits != 0) && !reset));
            chk("link_v", 64'(link_v), 64'(m_link_v));
            chk("link_data", 64'(link_data), 64'(m_data));
            chk("error", 64'(error), 64'(m_err));
            chk("credit_range", 64'(credit_count <= 4'(MAX)), 64'(1));
        end
        if (reset) begin
            m_valid   = 1'b1;
            m_credits = MAX;
            m_tok     = 1'b0;
            m_err     = 1'b0;
            m_link_v  = 1'b0;
            m_data    = '0;
        end else if (m_valid) begin
            xfer = src.v && (m_credits != 0);
            if (xfer) expq.push_back(src.data);
            tok_edge = token && !m_tok;
            m_tok    = token;
            sum = m_credits - (xfer ? 1 : 0) + (tok_edge ? T : 0);
            if (sum > MAX) begin
                m_credits = MAX;
                if (ERR_EN) m_err = 1'b1;
            end else begin
                m_credits = sum;
            end
            m_link_v = xfer;
            if (xfer) m_data = src.data;
        end
    end

    // Scoreboard monitor: every link word must be the oldest accepted word.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (m_valid && link_v === 1'b1) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL scoreboard: link word %0h with nothing expected", link_data);
            end else begin
                e = expq.pop_front();
                chk("scoreboard_word", 64'(link_data), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1;
        token = 1'b0;
        src.v = 1'b0;
        src.data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Stream 0..9 with no tokens: only 8 go out.
        w = 0;
        for (int i = 0; i < 12; i++) begin
            src.v = 1'b1;
            src.data = W'(w);
            @(negedge clk); #1;
            if (src.ready_and) w++;
            tick();
        end
        chk("t1_accepted", 64'(w), 64'(8));
        chk("t1_credits", 64'(credit_count), 64'(0));
        chk("t1_ready", 64'(src.ready_and), 64'(0));

        // One token edge at zero credits releases words 8 and 9.
        token = 1'b1;
        @(negedge clk); #1;
        chk("t2_credits_before", 64'(credit_count), 64'(0));
        tick();
        chk("t2_credits_after", 64'(credit_count), 64'(2));
        chk("t2_ready", 64'(src.ready_and), 64'(1));
        token = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src.data = W'(w);
            @(negedge clk); #1;
            if (src.ready_and) w++;
            tick();
        end
        chk("t2_accepted", 64'(w), 64'(10));
        chk("t2_credits_end", 64'(credit_count), 64'(0));

        // Refill to 8, then overflow with one more edge.
        src.v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            token = 1'b1; tick();
            token = 1'b0; tick();
        end
        chk("t3_full", 64'(credit_count), 64'(8));
        token = 1'b1; tick();
        token = 1'b0; tick();
        chk("t3_saturate", 64'(credit_count), 64'(8));
        chk("t3_error", 64'(error), 64'(ERR_EN));

        // Down to 3, then token edge and transfer together.
        src.v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            src.data = W'(w); w++;
            tick();
        end
        src.v = 1'b0;
        chk("t4_three", 64'(credit_count), 64'(3));
        token = 1'b1; src.v = 1'b1; src.data = W'(w); w++;
        tick();
        src.v = 1'b0; token = 1'b0;
        chk("t4_credits", 64'(credit_count), 64'(4));
        chk("t4_link_v", 64'(link_v), 64'(1));

        // Reach 5 credits with a word in flight, then reset.
        tick();
        token = 1'b1; src.v = 1'b1; src.data = W'(w); w++;
        tick();
        reset = 1'b1;
        #1;
        chk("t5_inflight_v", 64'(link_v), 64'(1));
        chk("t5_credits", 64'(credit_count), 64'(5));
        chk("t5_ready_in_reset", 64'(src.ready_and), 64'(0));
        tick();
        chk("t5_v_dropped", 64'(link_v), 64'(0));
        chk("t5_credits_reset", 64'(credit_count), 64'(8));
        chk("t5_error_reset", 64'(error), 64'(0));
        src.v = 1'b0;
        reset = 1'b0;
        #1;
        chk("t5_ready_release", 64'(src.ready_and), 64'(1));
        tick();
        chk("t5_token_across_reset", 64'(credit_count), 64'(8));
        chk("t5_error_after", 64'(error), 64'(ERR_EN));
        token = 1'b0;
        tick();

        // Random traffic with token toggling every 4 cycles.
        for (int i = 0; i < 400; i++) begin
            src.v    = ($urandom_range(0, 2) != 0);
            src.data = W'($urandom);
            token    = ((i / 4) % 2) == 1;
            tick();
        end
        src.v = 1'b0;
        token = 1'b0;
        repeat (3) tick();
        chk("scoreboard_drain", 64'(expq.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
